// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and constants for the instruction memory loader
package imem_loader_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int BYTES_PER_WORD = 4;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] index);
        return base + (index << 2);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - packs a byte stream big-endian into 32-bit words
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [7:0]  i_byte,
    output logic        o_word_full,
    output logic [31:0] o_word
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  r_count;
    logic [23:0] r_stage;
    logic [31:0] r_word;

    // The first three bytes wait in a staging register; the word register only
    // changes when the fourth byte lands, so it holds steady between writes.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_count <= 2'd0;
            r_stage <= 24'd0;
            r_word  <= 32'd0;
        end else if (i_clear) begin
            r_count <= 2'd0;
            r_stage <= 24'd0;
        end else if (i_load) begin
            r_count <= r_count + 2'd1;
            if (r_count == LAST_LANE) begin
                r_word <= {r_stage, i_byte};
            end else begin
                r_stage <= {r_stage[15:0], i_byte};
            end
        end
    end

    assign o_word_full = (r_count == LAST_LANE);
    assign o_word      = r_word;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - fills instruction memory from a byte stream, then releases the core
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Start,
    input  logic [ADDR_W:0] WordCount,
    input  logic [7:0]      ByteIn,
    input  logic            ByteValid,
    output logic            ByteReady,
    output logic            MemWriteEn,
    output logic [31:0]     MemAddr,
    output logic [31:0]     MemWriteData,
    output logic            CoreRst,
    output logic            Busy,
    output logic            Done
);

    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_mem_addr;

    logic              w_accept;
    logic              w_start;
    logic              w_word_full;
    logic              w_last;
    logic [ADDR_W:0]   w_count_sat;

    assign w_accept    = (r_state == ST_COLLECT) && ByteValid;
    assign w_start     = Start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_count_sat = (WordCount > MAX_COUNT) ? MAX_COUNT : WordCount;
    // Checking for the last word before incrementing keeps the index from wrapping.
    assign w_last      = (({1'b0, r_index} + ONE) == r_count);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= ST_IDLE;
            r_index    <= '0;
            r_count    <= '0;
            r_mem_addr <= BASE_ADDR;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        if (WordCount == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_count <= w_count_sat;
                            r_index <= '0;
                            r_state <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (w_accept && w_word_full) begin
                        r_mem_addr <= word_addr(BASE_ADDR, 32'(r_index));
                        r_state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_index <= r_index + 1'b1;
                        r_state <= ST_COLLECT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    imem_loader_byte_packer u_packer (
        .Clk         (Clk),
        .Rst         (Rst),
        .i_clear     (w_start),
        .i_load      (w_accept),
        .i_byte      (ByteIn),
        .o_word_full (w_word_full),
        .o_word      (MemWriteData)
    );

    assign ByteReady  = (r_state == ST_COLLECT);
    assign MemWriteEn = (r_state == ST_WRITE);
    assign Busy       = (r_state == ST_COLLECT) || (r_state == ST_WRITE);
    assign Done       = (r_state == ST_DONE);
    assign CoreRst    = (r_state != ST_DONE);
    assign MemAddr    = r_mem_addr;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [8:0]  WordCount;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        MemWriteEn;
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
    logic        CoreRst;
    logic        Busy;
    logic        Done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobes = 0;
    logic [31:0] last_addr, last_data;

    imem_loader dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Start        (Start),
        .WordCount    (WordCount),
        .ByteIn       (ByteIn),
        .ByteValid    (ByteValid),
        .ByteReady    (ByteReady),
        .MemWriteEn   (MemWriteEn),
        .MemAddr      (MemAddr),
        .MemWriteData (MemWriteData),
        .CoreRst      (CoreRst),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (MemWriteEn === 1'b1) begin
            n_strobes++;
            last_addr = MemAddr;
            last_data = MemWriteData;
            check("write_byteready_low", {31'd0, ByteReady}, 32'd0);
            check("write_corerst_high", {31'd0, CoreRst}, 32'd1);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_load(input logic [8:0] wc);
        Start = 1'b1;
        WordCount = wc;
        tick();
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        ByteIn = b;
        ByteValid = 1'b1;
        forever begin
            @(negedge Clk);
            if (ByteReady) break;
            n++;
            if (n > 200) begin
                check("byte_timeout", 32'd0, 32'd1);
                ByteValid = 1'b0;
                return;
            end
        end
        tick();
        ByteValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, max_gap)) tick();
            send_byte(w[31-8*k -: 8]);
        end
    endtask

    typedef struct {
        bit          new_load;
        logic [8:0]  wc;
        logic [7:0]  b0, b1, b2, b3;
        int          gap;
        bit          last;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int s0;
        logic [31:0] w;

        vecs[0] = '{1'b1, 9'd3, 8'h12, 8'h34, 8'h56, 8'h78, 0, 1'b0, 32'h0000_0000, 32'h1234_5678};
        vecs[1] = '{1'b0, 9'd0, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 5, 1'b0, 32'h0000_0004, 32'hA1B2_C3D4};
        vecs[2] = '{1'b0, 9'd0, 8'h00, 8'hFF, 8'h00, 8'hFF, 5, 1'b1, 32'h0000_0008, 32'h00FF_00FF};
        vecs[3] = '{1'b1, 9'd1, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 3, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF};

        Rst = 1'b1; Start = 1'b0; WordCount = '0; ByteIn = '0; ByteValid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_outputs", {27'd0, CoreRst, Done, ByteReady, MemWriteEn, Busy}, 32'h10);
        check("rst_memaddr", MemAddr, 32'h0);
        check("rst_memdata", MemWriteData, 32'h0);
        @(negedge Clk);
        Rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_outputs", {27'd0, CoreRst, Done, ByteReady, MemWriteEn, Busy}, 32'h10);
        end

        // WordCount=0 goes straight to DONE and never opens the byte port
        ByteIn = 8'h77; ByteValid = 1'b1;
        s0 = n_strobes;
        start_load(9'd0);
        check("wc0_state", {28'd0, Done, Busy, CoreRst, ByteReady}, 32'h8);
        repeat (3) begin
            tick();
            check("wc0_no_ready", {31'd0, ByteReady}, 32'd0);
        end
        check("wc0_no_strobe", n_strobes - s0, 32'd0);
        ByteValid = 1'b0;

        // single word
        s0 = n_strobes;
        start_load(9'd1);
        check("single_reload", {30'd0, CoreRst, Busy}, 32'h3);
        send_byte(8'h8C); send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
        check("single_we", {31'd0, MemWriteEn}, 32'd1);
        check("single_addr", MemAddr, 32'h0);
        check("single_data", MemWriteData, 32'h8C01_0004);
        tick();
        check("single_done", {29'd0, Done, CoreRst, MemWriteEn}, 32'h4);
        check("single_hold", MemWriteData, 32'h8C01_0004);
        check("single_count", n_strobes - s0, 32'd1);

        // table-driven loads with random byte gaps
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].new_load) begin
                start_load(vecs[i].wc);
                check("vec_busy", {30'd0, Busy, CoreRst}, 32'h3);
            end
            s0 = n_strobes;
            w = {vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3};
            send_word(w, vecs[i].gap);
            check("vec_we", {30'd0, MemWriteEn, ByteReady}, 32'h2);
            check("vec_addr", MemAddr, vecs[i].exp_addr);
            check("vec_data", MemWriteData, vecs[i].exp_data);
            tick();
            check("vec_strobes", n_strobes - s0, 32'd1);
            if (vecs[i].last)
                check("vec_done", {29'd0, Done, CoreRst, ByteReady}, 32'h4);
            else
                check("vec_next", {29'd0, Done, CoreRst, ByteReady}, 32'h3);
        end

        // reload from DONE; Start pulses while busy must not alter the count
        s0 = n_strobes;
        start_load(9'd2);
        check("reload_busy", {30'd0, CoreRst, Busy}, 32'h3);
        send_word(32'h0102_0304, 0);
        check("reload_w0_addr", MemAddr, 32'h0);
        check("reload_w0_data", MemWriteData, 32'h0102_0304);
        start_load(9'd1);
        check("ignore_start_write", {30'd0, Busy, Done}, 32'h2);
        start_load(9'd1);
        check("ignore_start_collect", {30'd0, Busy, Done}, 32'h2);
        send_word(32'h0506_0708, 2);
        check("reload_w1_addr", MemAddr, 32'h4);
        check("reload_w1_data", MemWriteData, 32'h0506_0708);
        tick();
        check("reload_done", {31'd0, Done}, 32'd1);
        check("reload_strobes", n_strobes - s0, 32'd2);

        // reset in the middle of a word
        s0 = n_strobes;
        start_load(9'd2);
        send_byte(8'hAA); send_byte(8'hBB);
        #2 Rst = 1'b1;
        #1;
        check("midrst_outputs", {27'd0, CoreRst, Done, ByteReady, MemWriteEn, Busy}, 32'h10);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (5) tick();
        check("midrst_no_strobe", n_strobes - s0, 32'd0);
        check("midrst_idle", {27'd0, CoreRst, Done, ByteReady, MemWriteEn, Busy}, 32'h10);
        start_load(9'd1);
        send_word(32'h1122_3344, 1);
        check("post_rst_addr", MemAddr, 32'h0);
        check("post_rst_data", MemWriteData, 32'h1122_3344);
        tick();
        check("post_rst_done", {31'd0, Done}, 32'd1);

        // oversize count saturates to 256 words; last address 0x3FC
        s0 = n_strobes;
        start_load(9'h1FF);
        for (int i = 0; i < 256; i++)
            send_word({8'(i), ~8'(i), 8'h5A, 8'hA5}, 0);
        tick();
        check("sat_strobes", n_strobes - s0, 32'd256);
        check("sat_last_addr", last_addr, 32'h0000_03FC);
        check("sat_last_data", last_data, 32'hFF00_5AA5);
        check("sat_done", {30'd0, Done, Busy}, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
